regs: RTL
=========

Name: regs

Overview:
- 32-entry RV64 integer general-purpose register file.
- Responder side of the decode-stage register read interface: the id stage drives two read addresses and receives read data combinationally.
- Also accepts one write per cycle from the writeback path (reg_we / reg_waddr forwarded down the pipeline).
- Provides a third read-only debug port for difftest/simulation register dumps.

Parameters:
- DATA_W, 64, register width (matches `RegBus).
- ADDR_W, 5, register index width (matches `RegAddrBus).
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- we_i  in  1  write enable from writeback.
- waddr_i  in  ADDR_W  write register index.
- wdata_i  in  DATA_W  write data.
- raddr1_i  in  ADDR_W  read port 1 index (from id reg1_raddr_o).
- rdata1_o  out  DATA_W  read port 1 data (to id reg1_rdata_i).
- raddr2_i  in  ADDR_W  read port 2 index (from id reg2_raddr_o).
- rdata2_o  out  DATA_W  read port 2 data (to id reg2_rdata_i).
- dbg_raddr_i  in  ADDR_W  debug read index.
- dbg_rdata_o  out  DATA_W  debug read data.
- wr_cnt_o  out  32  count of committed writes to non-zero registers; saturating.

Behaviour:
- Storage: NUM_REGS x DATA_W flops. Entry 0 is never written; x0 always reads 0.
- Reset: while rst=1 at a rising edge, every entry clears to 0 and wr_cnt_o clears to 0. All clearing completes in that single edge. A write presented in the same cycle as rst is dropped.
- Write:
  - At a rising edge with rst=0, we_i=1 and waddr_i!=0, entry[waddr_i] <= wdata_i.
  - The same edge increments wr_cnt_o; it saturates at 0xFFFF_FFFF.
  - we_i=1 with waddr_i=0 is a no-op; the counter does not increment.
- Read (ports 1, 2 and dbg):
  - Purely combinational, zero latency.
  - If raddr==0, data = 0.
  - Else, if we_i=1, rst=0 and waddr_i==raddr, data = wdata_i (write-through bypass). This lets decode see a result written back in the same cycle.
  - Else, data = entry[raddr].
- Reads during reset: rdata outputs reflect the current stored contents, with bypass suppressed while rst=1. From the cycle after reset, all reads return 0.
- Simultaneous events:
  - Both read ports and the debug port may address the same register, and the register being written. All of them see the same bypassed value.
- Outputs: all read data outputs are combinational. wr_cnt_o is registered; its reset value is 0.
- No X propagation: every out-of-range index is impossible because NUM_REGS = 2**ADDR_W. An assertion checks this parameter relation at elaboration.

Decomposition:
- Constants `ZeroReg, `ZeroWord, `RegBus, `RegAddrBus, `WriteEnable and `WriteDisable come from the shared defines.v.
- Add `RegNum (32) to defines.v.
- One sub-module is natural: regs_rport, a single combinational read port with bypass and x0 masking. It is instantiated three times (port 1, port 2, dbg).

Test Plan:
- Reset clear: write 0x1234 to x5, then assert rst for 1 cycle. Next cycle rdata1 (raddr1=5) = 0 and wr_cnt_o = 0.
- Basic write/read: we=1, waddr=3, wdata=0xDEAD_BEEF_0000_0001. Next cycle with we=0, raddr1=3 gives 0xDEAD_BEEF_0000_0001, and wr_cnt_o increments by 1.
- x0 immutability: we=1, waddr=0, wdata=0xFFFF_FFFF_FFFF_FFFF. Then raddr1=0 and raddr2=0 both read 0, and wr_cnt_o is unchanged.
- Bypass: x7 holds 0x11. In the same cycle drive we=1, waddr=7, wdata=0x22 and raddr1=raddr2=dbg=7. All three outputs read 0x22 in that cycle, and stored x7 = 0x22 afterwards.
- Reset vs write collision: rst=1 and we=1, waddr=9, wdata=0x55 in the same cycle. Afterwards x9 reads 0, and rdata for raddr=9 during that cycle shows the stored value, not 0x55.
- Full sweep: write x1..x31 with value = index*0x0101. Read back all via port 1, port 2 and dbg. All values match, x0 = 0, and wr_cnt_o = 31.

Source files
------------

// File: rtl/regs_pkg.sv
// Shared constants for the integer register file: widths, index/word zero values
// and write-enable levels used by the register file and its read ports.
package regs_pkg;

    localparam int unsigned REG_DATA_W = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_NUM    = 32;
    localparam int unsigned CNT_W      = 32;

    localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG     = '0;
    localparam logic                  WRITE_ENABLE = 1'b1;
    localparam logic [CNT_W-1:0]      CNT_MAX      = '1;

endpackage

// File: rtl/regs_if.sv
// Decode/writeback-facing bundle of the register file: two decode read ports,
// one writeback write port, a debug read port and the write counter.
interface regs_if #(
    parameter int unsigned DATA_W = regs_pkg::REG_DATA_W,
    parameter int unsigned ADDR_W = regs_pkg::REG_ADDR_W
) ();

    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;
    logic [ADDR_W-1:0] dbg_raddr_i;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic [31:0]       wr_cnt_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr1_i, raddr2_i, dbg_raddr_i,
        input  rdata1_o, rdata2_o, dbg_rdata_o, wr_cnt_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr1_i, raddr2_i, dbg_raddr_i,
        output rdata1_o, rdata2_o, dbg_rdata_o, wr_cnt_o
    );

endinterface

// File: rtl/regs_rport.sv
// One combinational register-file read port: x0 reads zero, and an in-flight
// writeback to the same index is forwarded unless reset is active.
module regs_rport
    import regs_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned NUM_REGS = REG_NUM
) (
    input  logic                             rst,
    input  logic                             we,
    input  logic [ADDR_W-1:0]                waddr,
    input  logic [DATA_W-1:0]                wdata,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  entries,
    input  logic [ADDR_W-1:0]                raddr,
    output logic [DATA_W-1:0]                rdata
);

    always_comb begin
        rdata = ZERO_WORD;
        if (raddr == ZERO_REG) begin
            rdata = ZERO_WORD;
        end else if (we == WRITE_ENABLE && !rst && waddr == raddr) begin
            rdata = wdata;
        end else begin
            rdata = entries[raddr];
        end
    end

endmodule

// File: rtl/regs.sv
// 32 x 64-bit RV64 integer register file with write-through bypass on both
// decode read ports and the debug port, plus a saturating committed-write counter.
module regs
    import regs_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned NUM_REGS = REG_NUM
) (
    input  logic clk,
    input  logic rst,
    regs_if.slave bus
);

    if (NUM_REGS != 2 ** ADDR_W) begin : g_bad_num_regs
        $error("regs: NUM_REGS must equal 2**ADDR_W");
    end

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            wr_en;

    assign wr_en = (bus.we_i == WRITE_ENABLE) && (bus.waddr_i != ZERO_REG);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.waddr_i] = bus.wdata_i;
        end
        regs_d[0] = ZERO_WORD;
        cnt_d = cnt_q;
        if (wr_en && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Reset wins over a same-cycle write: both storage and counter clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.wr_cnt_o = cnt_q;

    regs_rport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_rport1 (
        .rst    (rst),
        .we     (bus.we_i),
        .waddr  (bus.waddr_i),
        .wdata  (bus.wdata_i),
        .entries(regs_q),
        .raddr  (bus.raddr1_i),
        .rdata  (bus.rdata1_o)
    );

    regs_rport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_rport2 (
        .rst    (rst),
        .we     (bus.we_i),
        .waddr  (bus.waddr_i),
        .wdata  (bus.wdata_i),
        .entries(regs_q),
        .raddr  (bus.raddr2_i),
        .rdata  (bus.rdata2_o)
    );

    regs_rport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_rport_dbg (
        .rst    (rst),
        .we     (bus.we_i),
        .waddr  (bus.waddr_i),
        .wdata  (bus.wdata_i),
        .entries(regs_q),
        .raddr  (bus.dbg_raddr_i),
        .rdata  (bus.dbg_rdata_o)
    );

endmodule
